pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/hazard_detect.sv | 24 ++
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared types and constants for the pipeline hazard controller
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_m_en;
        logic m_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_m_flush;
        logic pc_src;
        logic mem_err;
    } ctl_t;

    // Freeze: every stage holds, nothing is replaced by a bubble
    localparam ctl_t CTL_FREEZE = '0;
    localparam ctl_t CTL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                    ex_m_en: 1'b1, m_wb_en: 1'b1, default: 1'b0};
    localparam ctl_t CTL_RESET  = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                    ex_m_flush: 1'b1, default: 1'b0};

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect : load-use hazard comparison between EX load and ID sources
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              load_use
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard
    assign load_use = ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : 5-stage pipeline stall/flush controller with memory timeout.
//             Define PIPE_CTRL_PERF_EN to add saturating stall/flush counters.
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned REG_AW      = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              m_branch,
    input  logic              m_zero,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_m_en,
    output logic              m_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_m_flush,
    output logic              pc_src,
`ifdef PIPE_CTRL_PERF_EN
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_count,
`endif
    output logic              mem_err
);

    localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    ctl_t       ctl;
    logic       load_use;
    logic       mem_stall;
    logic       take;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use    (load_use)
    );

    assign mem_stall = (m_mem_read | m_mem_write) & ~dmem_ready;
    assign take      = m_branch & m_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl     = CTL_RUN;
        if (rst) begin
            ctl = CTL_RESET;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        ctl = CTL_FREEZE;
                        if (state_q == ST_RUN) begin
                            state_d = ST_MEM_WAIT;
                            cnt_d   = 8'd1;
                        end else if (cnt_q == TIMEOUT) begin
                            state_d = ST_ERR;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        // Release cycle from MEM_WAIT resolves hazards like any RUN cycle
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        if (take) begin
                            ctl.pc_src      = 1'b1;
                            ctl.if_id_flush = 1'b1;
                            ctl.id_ex_flush = 1'b1;
                            ctl.ex_m_flush  = 1'b1;
                        end else if (load_use) begin
                            ctl.pc_en       = 1'b0;
                            ctl.if_id_en    = 1'b0;
                            ctl.id_ex_flush = 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    ctl         = CTL_FREEZE;
                    ctl.mem_err = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                    ctl     = CTL_FREEZE;
                end
            endcase
        end
    end

    assign pc_en       = ctl.pc_en;
    assign if_id_en    = ctl.if_id_en;
    assign id_ex_en    = ctl.id_ex_en;
    assign ex_m_en     = ctl.ex_m_en;
    assign m_wb_en     = ctl.m_wb_en;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;
    assign ex_m_flush  = ctl.ex_m_flush;
    assign pc_src      = ctl.pc_src;
    assign mem_err     = ctl.mem_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!ctl.pc_en && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (ctl.pc_src && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int unsigned REG_AW = 5;

    // {pc_en,if_id_en,id_ex_en,ex_m_en,m_wb_en,if_id_fl,id_ex_fl,ex_m_fl,pc_src,mem_err}
    localparam logic [9:0] E_RUN  = 10'b11111_000_0_0;
    localparam logic [9:0] E_FRZ  = 10'b00000_000_0_0;
    localparam logic [9:0] E_ERR  = 10'b00000_000_0_1;
    localparam logic [9:0] E_RST  = 10'b00000_111_0_0;
    localparam logic [9:0] E_TAKE = 10'b11111_111_1_0;
    localparam logic [9:0] E_LU   = 10'b00111_010_0_0;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
    logic              ex_mem_read, m_branch, m_zero, m_mem_read, m_mem_write, dmem_ready;
    logic              pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en;
    logic              if_id_flush, id_ex_flush, ex_m_flush, pc_src, mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0]       stall_cycles, flush_count;
`endif
    logic [9:0]        outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4), .REG_AW(REG_AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .m_branch    (m_branch),
        .m_zero      (m_zero),
        .m_mem_read  (m_mem_read),
        .m_mem_write (m_mem_write),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_m_en     (ex_m_en),
        .m_wb_en     (m_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ex_m_flush  (ex_m_flush),
        .pc_src      (pc_src),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles(stall_cycles),
        .flush_count (flush_count),
`endif
        .mem_err     (mem_err)
    );

    assign outs = {pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
                   if_id_flush, id_ex_flush, ex_m_flush, pc_src, mem_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [9:0] exp);
        #1;
        chk(tag, {22'd0, outs}, {22'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        id_rs = '0; id_rt = '0; ex_rt = '0; ex_mem_read = 1'b0;
        m_branch = 1'b0; m_zero = 1'b0; m_mem_read = 1'b0; m_mem_write = 1'b0;
        dmem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        look("reset_outputs", E_RST);
`ifdef PIPE_CTRL_PERF_EN
        chk("reset_stall_cnt", {16'd0, stall_cycles}, 32'd0);
        chk("reset_flush_cnt", {16'd0, flush_count}, 32'd0);
`endif
        rst = 1'b0;
        look("idle_run", E_RUN);
        tick();

        // Memory stall: three not-ready cycles, released on the fourth
        m_mem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look($sformatf("mem_stall_%0d", i), E_FRZ);
            tick();
        end
        dmem_ready = 1'b1;
        look("mem_release", E_RUN);
        tick();
        idle_inputs();
        look("after_release_run", E_RUN);
        tick();

        // Taken branch, not-taken branch, taken branch
        m_branch = 1'b1; m_zero = 1'b1;
        look("branch_taken", E_TAKE);
        tick();
        m_zero = 1'b0;
        look("branch_not_taken", E_RUN);
        tick();
        m_zero = 1'b1;
        look("branch_taken_2", E_TAKE);
        tick();
        idle_inputs();
        look("after_branch_run", E_RUN);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cycles", {16'd0, stall_cycles}, 32'd3);
        chk("perf_flush_count", {16'd0, flush_count}, 32'd2);
`endif
        tick();

        // Load-use hazards
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
        look("load_use_rs", E_LU);
        tick();
        ex_mem_read = 1'b0;
        look("after_load_use", E_RUN);
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
        look("load_use_rt", E_LU);
        tick();
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        look("load_r0_no_stall", E_RUN);
        tick();
        ex_mem_read = 1'b0; ex_rt = 5'd5; id_rs = 5'd5;
        look("no_load_no_stall", E_RUN);
        tick();

        // All three events at once: freeze, then branch wins on release
        m_branch = 1'b1; m_zero = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        m_mem_read = 1'b1; dmem_ready = 1'b0;
        look("combo_stall_0", E_FRZ);
        tick();
        look("combo_stall_1", E_FRZ);
        tick();
        dmem_ready = 1'b1;
        look("combo_release_take", E_TAKE);
        tick();
        idle_inputs();
        look("after_combo_run", E_RUN);
        tick();

        // Timeout: RUN stall cycle, then MEM_WAIT counts 1..4, then ERR
        m_mem_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            look($sformatf("timeout_wait_%0d", i), E_FRZ);
            tick();
        end
        look("timeout_err", E_ERR);
        m_mem_write = 1'b0; dmem_ready = 1'b1;
        tick();
        look("err_sticky", E_ERR);
        tick();
        rst = 1'b1;
        look("reset_in_err", E_RST);
        tick();
        rst = 1'b0;
        idle_inputs();
        look("after_err_reset", E_RUN);
`ifdef PIPE_CTRL_PERF_EN
        chk("reset_clears_stall", {16'd0, stall_cycles}, 32'd0);
`endif
        tick();

`ifdef PIPE_CTRL_PERF_EN
        // Saturation: preload both counters, then trigger one of each event
        force dut.stall_cycles_q = 16'hFFFF;
        force dut.flush_count_q  = 16'hFFFF;
        #1;
        release dut.stall_cycles_q;
        release dut.flush_count_q;
        m_branch = 1'b1; m_zero = 1'b1;
        tick();
        m_branch = 1'b0; m_zero = 1'b0;
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        tick();
        idle_inputs();
        #1;
        chk("stall_saturated", {16'd0, stall_cycles}, 32'h0000FFFF);
        chk("flush_saturated", {16'd0, flush_count}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
